rf_ook_keyer: RTL and testbench

- Parametrised on-off-keyed RF transmitter.
- Derives a programmable carrier from CLK, serialises data words MSB-first into a keying envelope, and drives rf as carrier AND key.
- Includes a heartbeat LED whose blink rate shows busy/idle.
- Sits between a byte source (UART/packet logic) and the rf pad.

---
 rtl/rf_ook_keyer.sv | 230 +++++++++++++++++++++++
 tb/tb_rf_ook_keyer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_ook_keyer.sv
// rf_ook_keyer: on-off-keyed RF transmitter.
// A word accepted on valid&ready is shifted out MSB-first as a keying envelope
// (key). Each bit lasts bit_len+1 CLK cycles, and GAP_BITS idle bit periods
// follow every word. A programmable carrier is derived from CLK, and
// rf = car & key is registered.
// A heartbeat LED blinks 4x faster while a frame is in progress.
// Optional build macro RF_OOK_MANCHESTER_EN: each bit becomes two half-periods
// (bit, ~bit), and gap periods are doubled to match.
module rf_ook_keyer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned BIT_W    = 16,
    parameter int unsigned CAR_W    = 8,
    parameter int unsigned GAP_BITS = 2,
    parameter int unsigned LED_W    = 22
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              en,
    input  logic [CAR_W-1:0]  car_half,
    input  logic [BIT_W-1:0]  bit_len,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              key,
    output logic              rf,
    output logic              led
);

    localparam int unsigned IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned GAP_W    = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam int unsigned GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              key_d;
    logic              done_d;
    logic [CAR_W-1:0]  car_cnt;
    logic              car;
    logic [LED_W-1:0]  hb;
    logic              bit_end;
    logic              sym_end;

`ifdef RF_OOK_MANCHESTER_EN
    logic              half_q, half_d;
`endif

    // Handshake availability; forced low while reset is asserted.
    assign ready = (state_q == IDLE) & en & RST_N;

    // End of one bit period; the >= compare absorbs a bit_len reduced mid-period.
    assign bit_end = (bit_cnt_q >= bit_len);

    // End of one symbol: a whole bit period (NRZ) or its second half (Manchester).
`ifdef RF_OOK_MANCHESTER_EN
    assign sym_end = bit_end & half_q;
`else
    assign sym_end = bit_end;
`endif

    // Carrier divider: toggle car every car_half+1 cycles while enabled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            car_cnt <= '0;
            car     <= 1'b0;
        end else if (!en) begin
            car_cnt <= '0;
            car     <= 1'b0;
        end else if (car_cnt >= car_half) begin
            car_cnt <= '0;
            car     <= ~car;
        end else begin
            car_cnt <= car_cnt + CAR_W'(1);
        end
    end

    // Gate the carrier with the envelope, registered so rf never glitches.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rf <= 1'b0;
        end else begin
            rf <= car & key;
        end
    end

    // Heartbeat: free-running counter, faster LED tap while a frame is active.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hb  <= '0;
            led <= 1'b0;
        end else begin
            hb  <= hb + LED_W'(1);
            led <= busy ? hb[LED_W-3] : hb[LED_W-1];
        end
    end

    // Keyer state and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            key       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
`ifdef RF_OOK_MANCHESTER_EN
            half_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            key       <= key_d;
            done      <= done_d;
            busy      <= (state_d != IDLE);
`ifdef RF_OOK_MANCHESTER_EN
            half_q    <= half_d;
`endif
        end
    end

    // Next-state and datapath decode for the keyer.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        key_d     = key;
        done_d    = 1'b0;
`ifdef RF_OOK_MANCHESTER_EN
        half_d    = half_q;
`endif

        if (!en) begin
            // Abort: clear everything without signalling completion.
            state_d   = IDLE;
            shreg_d   = '0;
            bit_idx_d = '0;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            key_d     = 1'b0;
`ifdef RF_OOK_MANCHESTER_EN
            half_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid) begin
                        state_d   = SEND;
                        shreg_d   = data;
                        bit_idx_d = IDX_W'(DATA_W - 1);
                        bit_cnt_d = '0;
                        key_d     = data[DATA_W-1];
`ifdef RF_OOK_MANCHESTER_EN
                        half_d    = 1'b0;
`endif
                    end
                end

                SEND: begin
                    bit_cnt_d = bit_end ? '0 : bit_cnt_q + BIT_W'(1);
`ifdef RF_OOK_MANCHESTER_EN
                    if (bit_end) begin
                        half_d = ~half_q;
                        if (!half_q) begin
                            key_d = ~shreg_q[DATA_W-1];
                        end
                    end
`endif
                    if (sym_end) begin
                        if (bit_idx_q != '0) begin
                            shreg_d   = shreg_q << 1;
                            key_d     = shreg_q[DATA_W-2];
                            bit_idx_d = bit_idx_q - IDX_W'(1);
                        end else begin
                            key_d = 1'b0;
                            if (GAP_BITS == 0) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d   = GAP;
                                gap_cnt_d = '0;
                            end
                        end
                    end
                end

                GAP: begin
                    key_d     = 1'b0;
                    bit_cnt_d = bit_end ? '0 : bit_cnt_q + BIT_W'(1);
`ifdef RF_OOK_MANCHESTER_EN
                    if (bit_end) begin
                        half_d = ~half_q;
                    end
`endif
                    if (sym_end) begin
                        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                            state_d   = IDLE;
                            done_d    = 1'b1;
                            gap_cnt_d = '0;
                        end else begin
                            gap_cnt_d = gap_cnt_q + GAP_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    key_d   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_ook_keyer.sv
// Directed bench for rf_ook_keyer: table of frames plus abort, reset, back-to-back
// and heartbeat sequences. Honours RF_OOK_MANCHESTER_EN when defined.
module tb_rf_ook_keyer;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned BIT_W    = 16;
    localparam int unsigned CAR_W    = 8;
    localparam int unsigned GAP_BITS = 2;
    localparam int unsigned LED_W    = 4;

`ifdef RF_OOK_MANCHESTER_EN
    localparam int MUL = 2;
`else
    localparam int MUL = 1;
`endif

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              en;
    logic [CAR_W-1:0]  car_half;
    logic [BIT_W-1:0]  bit_len;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready, busy, done, key, rf, led;

    rf_ook_keyer #(
        .DATA_W  (DATA_W),
        .BIT_W   (BIT_W),
        .CAR_W   (CAR_W),
        .GAP_BITS(GAP_BITS),
        .LED_W   (LED_W)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .en      (en),
        .car_half(car_half),
        .bit_len (bit_len),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .key     (key),
        .rf      (rf),
        .led     (led)
    );

    always #5 CLK = ~CLK;

    // Reference carrier; car_prev is the carrier value one cycle earlier.
    logic             car_m, car_prev;
    logic [CAR_W-1:0] cnt_m;
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            car_m    <= 1'b0;
            car_prev <= 1'b0;
            cnt_m    <= '0;
        end else begin
            car_prev <= car_m;
            if (!en) begin
                car_m <= 1'b0;
                cnt_m <= '0;
            end else if (cnt_m >= car_half) begin
                car_m <= ~car_m;
                cnt_m <= '0;
            end else begin
                cnt_m <= cnt_m + 8'd1;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected envelope k cycles after the accept edge.
    function automatic logic key_exp(input logic [7:0] pat, input int bl, input int k);
        int p;
        p = k / (bl + 1);
`ifdef RF_OOK_MANCHESTER_EN
        if (p >= 16) return 1'b0;
        return pat[7 - p / 2] ^ (p % 2 == 1);
`else
        if (p >= 8) return 1'b0;
        return pat[7 - p];
`endif
    endfunction

    // Entered at the negedge where valid is high and ready expected; checks whole frame.
    task automatic check_frame(input logic [7:0] pat, input int bl, input int lat,
                               input int rf_hi, input bit hold, input logic [7:0] nxt,
                               input string nm);
        int   hi;
        logic kp, ke;
        hi = 0;
        kp = 1'b0;
        chk({nm, " ready"}, int'(ready), 1);
        for (int k = 0; k < lat; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                if (hold) data = nxt;
                else valid = 1'b0;
            end
            ke = key_exp(pat, bl, k);
            chk({nm, " key"}, int'(key), int'(ke));
            chk({nm, " busy"}, int'(busy), 1);
            chk({nm, " done_early"}, int'(done), 0);
            chk({nm, " rf"}, int'(rf), int'(car_prev & kp));
            hi += int'(rf);
            kp = ke;
        end
        @(negedge CLK);
        chk({nm, " done"}, int'(done), 1);
        chk({nm, " busy_end"}, int'(busy), 0);
        chk({nm, " key_end"}, int'(key), 0);
        chk({nm, " ready_end"}, int'(ready), 1);
        chk({nm, " rf_end"}, int'(rf), int'(car_prev & kp));
        hi += int'(rf);
        chk({nm, " rf_high_count"}, hi, rf_hi);
    endtask

    typedef struct {
        logic [7:0] data;
        int         bl;
        int         ch;
        int         lat;
        int         rf_hi;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  last, nint;
        logic lp;
        bit  seen;

        tbl[0] = '{8'hA5, 3, 0, 40 * MUL, (MUL == 2) ? 16 : 8};
        tbl[1] = '{8'hFF, 11, 2, 120 * MUL, 48};
        tbl[2] = '{8'h00, 1, 0, 20 * MUL, (MUL == 2) ? 8 : 0};
        tbl[3] = '{8'h3C, 1, 0, 20 * MUL, (MUL == 2) ? 8 : 4};

        RST_N    = 1'b0;
        en       = 1'b1;
        valid    = 1'b0;
        data     = '0;
        car_half = '0;
        bit_len  = 16'd3;
        repeat (3) @(negedge CLK);
        chk("rst key", int'(key), 0);
        chk("rst rf", int'(rf), 0);
        chk("rst done", int'(done), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst led", int'(led), 0);
        chk("rst ready", int'(ready), 0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("idle ready", int'(ready), 1);

        // Table of single frames.
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            bit_len  = 16'(tbl[i].bl);
            car_half = 8'(tbl[i].ch);
            data     = tbl[i].data;
            valid    = 1'b1;
            check_frame(tbl[i].data, tbl[i].bl, tbl[i].lat, tbl[i].rf_hi, 1'b0, 8'h00,
                        $sformatf("vec%0d", i));
        end

        // Back-to-back with valid held: second accept on the done cycle.
        @(negedge CLK);
        bit_len  = 16'd3;
        car_half = 8'd0;
        data     = 8'h80;
        valid    = 1'b1;
        check_frame(8'h80, 3, 40 * MUL, (MUL == 2) ? 16 : 2, 1'b1, 8'h01, "b2b_first");
        check_frame(8'h01, 3, 40 * MUL, (MUL == 2) ? 16 : 2, 1'b0, 8'h00, "b2b_second");

        // Abort: drop en at cycle 10 of a 0xFF frame.
        @(negedge CLK);
        data  = 8'hFF;
        valid = 1'b1;
        @(negedge CLK);
        valid = 1'b0;
        chk("abort started", int'(busy), 1);
        repeat (9) @(negedge CLK);
        chk("abort key_before", int'(key), 1);
        en = 1'b0;
        chk("abort ready_en0", int'(ready), 0);
        @(negedge CLK);
        chk("abort key", int'(key), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        @(negedge CLK);
        chk("abort rf", int'(rf), 0);
        seen = 1'b0;
        valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (done || busy || ready) seen = 1'b1;
        end
        chk("abort quiet", int'(seen), 0);
        valid = 1'b0;
        en = 1'b1;
        #1;
        chk("abort ready_back", int'(ready), 1);

        // Asynchronous reset mid-frame.
        @(negedge CLK);
        data  = 8'hA5;
        valid = 1'b1;
        @(negedge CLK);
        valid = 1'b0;
        repeat (4) @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("areset key", int'(key), 0);
        chk("areset rf", int'(rf), 0);
        chk("areset busy", int'(busy), 0);
        chk("areset done", int'(done), 0);
        chk("areset led", int'(led), 0);
        chk("areset ready", int'(ready), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Idle heartbeat: toggles every 8 cycles.
        last = -1;
        nint = 0;
        lp   = led;
        for (int k = 0; k < 48; k++) begin
            @(negedge CLK);
            if (led != lp) begin
                if (last >= 0) begin
                    chk("led idle interval", k - last, 8);
                    nint++;
                end
                last = k;
            end
            lp = led;
        end
        chk("led idle toggles", int'(nint >= 3), 1);

        // Busy heartbeat: toggles every 2 cycles.
        data    = 8'hA5;
        bit_len = 16'd7;
        valid   = 1'b1;
        @(negedge CLK);
        valid = 1'b0;
        last = -1;
        nint = 0;
        lp   = led;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (k >= 4 && led != lp) begin
                if (last >= 0) begin
                    chk("led busy interval", k - last, 2);
                    nint++;
                end
                last = k;
            end
            lp = led;
        end
        chk("led busy toggles", int'(nint >= 20), 1);
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge CLK);
            if (done) seen = 1'b1;
        end
        chk("led frame done", int'(seen), 1);

        // After reset, a normal frame is accepted.
        @(negedge CLK);
        bit_len  = 16'(tbl[0].bl);
        car_half = 8'(tbl[0].ch);
        data     = tbl[0].data;
        valid    = 1'b1;
        check_frame(tbl[0].data, tbl[0].bl, tbl[0].lat, tbl[0].rf_hi, 1'b0, 8'h00, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
